// File: rtl/reg_sel_pkg.sv
// Shared types and helpers for the register-select sequencer: state encoding,
// the "no register" all-ones code and the wrapping index increment.
package reg_sel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam int unsigned MAX_REGS = 64;

    // Low n bits set: the inactive (no register) value of an n-bit active-low select bus.
    function automatic logic [MAX_REGS-1:0] no_reg_code(input int unsigned n);
        if (n >= MAX_REGS) begin
            return '1;
        end
        return (MAX_REGS'(1) << n) - MAX_REGS'(1);
    endfunction

    // Next register index, wrapping from n-1 back to 0.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        if (idx + 1 >= n) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage

// File: rtl/onehot_n_decoder.sv
// Combinational active-low one-hot decoder; out-of-range indices give all ones.
module onehot_n_decoder #(
    parameter int unsigned SELECTION = 5,
    parameter int unsigned NUM_REGS  = 11
) (
    input  logic [SELECTION-1:0] idx,
    output logic [NUM_REGS-1:0]  deco
);

    always_comb begin
        deco = '1;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (idx == SELECTION'(i)) begin
                deco[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_select_sequencer.sv
// Register-file select sequencer: single strobes and autonomous index scans with
// hold, wrap-around and done pulse. Optional feature macro: REG_SEL_ERR_EN.
module reg_select_sequencer
    import reg_sel_pkg::*;
#(
    parameter int unsigned SELECTION = 5,
    parameter int unsigned NUM_REGS  = 11
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_InHigh,
    input  logic [SELECTION-1:0] sSelIn,
    input  logic                 sLoad,
    input  logic                 sScanStart,
    input  logic [SELECTION-1:0] sScanFirst,
    input  logic [SELECTION-1:0] sScanLast,
    input  logic                 sHold,
    output logic [NUM_REGS-1:0]  sOutDeco,
    output logic [SELECTION-1:0] sIndex,
    output logic                 sBusy,
    output logic                 sDone,
    output logic                 sErr
);

    localparam logic [NUM_REGS-1:0]  NO_REG  = NUM_REGS'(no_reg_code(NUM_REGS));
    localparam logic [SELECTION-1:0] MAX_IDX = SELECTION'(NUM_REGS - 1);

    state_t               state;
    logic [SELECTION-1:0] last_q;
    logic                 held_q;

    logic                 first_oor_c;
    logic                 last_oor_c;
    logic                 range_err_c;
    logic [SELECTION-1:0] first_c;
    logic [SELECTION-1:0] last_c;
    logic                 strobed_c;
    logic                 scan_end_c;
    logic [SELECTION-1:0] next_c;
    logic [SELECTION-1:0] dec_idx_c;
    logic [NUM_REGS-1:0]  dec_c;

    assign first_oor_c = 32'(sScanFirst) >= NUM_REGS;
    assign last_oor_c  = 32'(sScanLast)  >= NUM_REGS;

`ifdef REG_SEL_ERR_EN
    assign range_err_c = first_oor_c | last_oor_c;
    assign first_c     = sScanFirst;
    assign last_c      = sScanLast;
`else
    assign range_err_c = 1'b0;
    assign first_c     = first_oor_c ? MAX_IDX : sScanFirst;
    assign last_c      = last_oor_c  ? MAX_IDX : sScanLast;
`endif

    // A scan cycle that was not held has just driven a strobe at sIndex.
    assign strobed_c  = (state == ST_SCAN) && !held_q;
    assign scan_end_c = strobed_c && (sIndex == last_q);
    assign next_c     = strobed_c ? SELECTION'(wrap_inc(32'(sIndex), NUM_REGS)) : sIndex;

    // Index whose select is loaded into the output register at the coming edge.
    always_comb begin
        dec_idx_c = sIndex;
        case (state)
            ST_IDLE: dec_idx_c = sScanStart ? first_c : sSelIn;
            ST_SCAN: dec_idx_c = next_c;
            default: dec_idx_c = sIndex;
        endcase
    end

    onehot_n_decoder #(
        .SELECTION (SELECTION),
        .NUM_REGS  (NUM_REGS)
    ) u_dec (
        .idx  (dec_idx_c),
        .deco (dec_c)
    );

    always_ff @(posedge CLOCK_50) begin
        if (RESET_InHigh) begin
            state    <= ST_IDLE;
            sOutDeco <= NO_REG;
            sIndex   <= '0;
            sBusy    <= 1'b0;
            sDone    <= 1'b0;
            sErr     <= 1'b0;
            last_q   <= '0;
            held_q   <= 1'b0;
        end else begin
            sDone <= 1'b0;
            sErr  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sOutDeco <= NO_REG;
                    sBusy    <= 1'b0;
                    held_q   <= 1'b0;
                    if (sScanStart) begin
                        if (range_err_c) begin
                            sErr <= 1'b1;
                        end else begin
                            state    <= ST_SCAN;
                            sIndex   <= first_c;
                            last_q   <= last_c;
                            sOutDeco <= dec_c;
                            sBusy    <= 1'b1;
                        end
                    end else if (sLoad) begin
                        state    <= ST_STROBE;
                        sIndex   <= sSelIn;
                        sOutDeco <= dec_c;
                        sBusy    <= 1'b1;
                    end
                end
                ST_STROBE: begin
                    state    <= ST_IDLE;
                    sOutDeco <= NO_REG;
                    sBusy    <= 1'b0;
                    sDone    <= 1'b1;
                end
                ST_SCAN: begin
                    if (scan_end_c) begin
                        state    <= ST_IDLE;
                        sOutDeco <= NO_REG;
                        sBusy    <= 1'b0;
                        sDone    <= 1'b1;
                        held_q   <= 1'b0;
                    end else begin
                        sIndex   <= next_c;
                        held_q   <= sHold;
                        sOutDeco <= sHold ? NO_REG : dec_c;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    sOutDeco <= NO_REG;
                    sBusy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_select_sequencer.sv
// Directed, table-driven bench for reg_select_sequencer (NUM_REGS=11, SELECTION=5).
module tb_reg_select_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  sel;
    logic        load;
    logic        start;
    logic [4:0]  first;
    logic [4:0]  last;
    logic        hold;
    logic [10:0] deco;
    logic [4:0]  idx;
    logic        busy;
    logic        done;
    logic        err;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [10:0] ONES = 11'h7FF;

    typedef struct {
        logic        rst;
        logic        load;
        logic [4:0]  sel;
        logic        start;
        logic [4:0]  first;
        logic [4:0]  last;
        logic        hold;
        logic [10:0] x_deco;
        logic [4:0]  x_idx;
        logic        x_busy;
        logic        x_done;
        logic        x_err;
    } vec_t;

    vec_t vt[$];

    always #5 clk = ~clk;

    reg_select_sequencer #(
        .SELECTION (5),
        .NUM_REGS  (11)
    ) dut (
        .CLOCK_50     (clk),
        .RESET_InHigh (rst),
        .sSelIn       (sel),
        .sLoad        (load),
        .sScanStart   (start),
        .sScanFirst   (first),
        .sScanLast    (last),
        .sHold        (hold),
        .sOutDeco     (deco),
        .sIndex       (idx),
        .sBusy        (busy),
        .sDone        (done),
        .sErr         (err)
    );

    function automatic logic [10:0] sel_n(input int i);
        logic [10:0] v;
        v = ONES;
        if (i < 11) v[i] = 1'b0;
        return v;
    endfunction

    task automatic add(input logic r, input logic ld, input int s, input logic st,
                       input int f, input int l, input logic h,
                       input logic [10:0] xd, input int xi, input logic xb,
                       input logic xdn, input logic xe);
        vec_t v;
        v.rst = r; v.load = ld; v.sel = 5'(s); v.start = st;
        v.first = 5'(f); v.last = 5'(l); v.hold = h;
        v.x_deco = xd; v.x_idx = 5'(xi); v.x_busy = xb; v.x_done = xdn; v.x_err = xe;
        vt.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int step_no, input logic [10:0] got,
                       input logic [10:0] exp);
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s step %0d: got %h expected %h", name, step_no, got, exp);
        end
    endtask

    task automatic chk_all(input int step_no, input logic [10:0] xd, input int xi,
                           input logic xb, input logic xdn, input logic xe);
        n_vec++;
        chk("deco", step_no, deco, xd);
        chk("index", step_no, 11'(idx), 11'(xi));
        chk("busy", step_no, 11'(busy), 11'(xb));
        chk("done", step_no, 11'(done), 11'(xdn));
        chk("err", step_no, 11'(err), 11'(xe));
    endtask

    initial begin
        int n;
        rst = 1'b1; sel = '0; load = 1'b0; start = 1'b0;
        first = '0; last = '0; hold = 1'b0;

        //   rst ld sel st  f  l  h   deco        idx bsy dn er
        add(1, 0, 0,  0,  0, 0, 0,  ONES,        0, 0, 0, 0);
        add(0, 0, 0,  0,  0, 0, 0,  ONES,        0, 0, 0, 0);
        // single strobe at 3 (hold ignored outside a scan)
        add(0, 1, 3,  0,  0, 0, 1,  11'b11111110111, 3, 1, 0, 0);
        add(0, 0, 0,  0,  0, 0, 0,  ONES,        3, 0, 1, 0);
        add(0, 0, 0,  0,  0, 0, 0,  ONES,        3, 0, 0, 0);
        // out-of-range single strobe is a no-register strobe, request still ignored while busy
        add(0, 1, 12, 0,  0, 0, 0,  ONES,       12, 1, 0, 0);
        add(0, 1, 5,  0,  0, 0, 0,  ONES,       12, 0, 1, 0);
        add(0, 0, 0,  0,  0, 0, 0,  ONES,       12, 0, 0, 0);
        // wrapped scan 9..1, sLoad in the start cycle loses, new scan while busy ignored
        add(0, 1, 4,  1,  9, 1, 0,  sel_n(9),    9, 1, 0, 0);
        add(0, 1, 4,  1,  2, 2, 0,  sel_n(10),  10, 1, 0, 0);
        add(0, 0, 0,  0,  0, 0, 0,  sel_n(0),    0, 1, 0, 0);
        add(0, 0, 0,  0,  0, 0, 0,  sel_n(1),    1, 1, 0, 0);
        add(0, 0, 0,  0,  0, 0, 0,  ONES,        1, 0, 1, 0);
        add(0, 0, 0,  0,  0, 0, 0,  ONES,        1, 0, 0, 0);
`ifdef REG_SEL_ERR_EN
        // out-of-range last: rejected
        add(0, 0, 0,  1,  8, 15, 0, ONES,        1, 0, 0, 1);
        add(0, 0, 0,  0,  0, 0, 0,  ONES,        1, 0, 0, 0);
        add(0, 0, 0,  0,  0, 0, 0,  ONES,        1, 0, 0, 0);
        add(0, 0, 0,  0,  0, 0, 0,  ONES,        1, 0, 0, 0);
`else
        // out-of-range last: clamped to 10
        add(0, 0, 0,  1,  8, 15, 0, sel_n(8),    8, 1, 0, 0);
        add(0, 0, 0,  0,  0, 0, 0,  sel_n(9),    9, 1, 0, 0);
        add(0, 0, 0,  0,  0, 0, 0,  sel_n(10),  10, 1, 0, 0);
        add(0, 0, 0,  0,  0, 0, 0,  ONES,       10, 0, 1, 0);
`endif
        // single-index scan, then back-to-back requests in the done cycle
        add(0, 0, 0,  1,  6, 6, 0,  sel_n(6),    6, 1, 0, 0);
        add(0, 1, 2,  0,  0, 0, 0,  ONES,        6, 0, 1, 0);
        add(0, 1, 7,  0,  0, 0, 0,  sel_n(7),    7, 1, 0, 0);
        add(0, 0, 0,  1,  4, 4, 0,  ONES,        7, 0, 1, 0);
        add(0, 0, 0,  1,  4, 4, 0,  sel_n(4),    4, 1, 0, 0);
        add(0, 0, 0,  0,  0, 0, 0,  ONES,        4, 0, 1, 0);
        // reset in the middle of a full scan
        add(0, 0, 0,  1,  0, 10, 0, sel_n(0),    0, 1, 0, 0);
        add(0, 0, 0,  0,  0, 0, 0,  sel_n(1),    1, 1, 0, 0);
        add(1, 0, 0,  0,  0, 0, 0,  ONES,        0, 0, 0, 0);
        add(0, 0, 0,  0,  0, 0, 0,  ONES,        0, 0, 0, 0);
        add(0, 0, 0,  0,  0, 0, 0,  ONES,        0, 0, 0, 0);

        for (int i = 0; i < vt.size(); i++) begin
            rst = vt[i].rst; load = vt[i].load; sel = vt[i].sel;
            start = vt[i].start; first = vt[i].first; last = vt[i].last;
            hold = vt[i].hold;
            step();
            chk_all(i, vt[i].x_deco, int'(vt[i].x_idx), vt[i].x_busy,
                    vt[i].x_done, vt[i].x_err);
        end
        rst = 1'b0; load = 1'b0; start = 1'b0; hold = 1'b0;

        // hold sequence: scan 0..4, hold sampled on two edges before index 2 strobes
        start = 1'b1; first = 5'd0; last = 5'd4;
        step(); chk_all(100, sel_n(0), 0, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        step(); chk_all(101, sel_n(1), 1, 1'b1, 1'b0, 1'b0);
        hold = 1'b1;
        step(); chk_all(102, ONES, 2, 1'b1, 1'b0, 1'b0);
        step(); chk_all(103, ONES, 2, 1'b1, 1'b0, 1'b0);
        hold = 1'b0;
        step(); chk_all(104, sel_n(2), 2, 1'b1, 1'b0, 1'b0);
        step(); chk_all(105, sel_n(3), 3, 1'b1, 1'b0, 1'b0);
        step(); chk_all(106, sel_n(4), 4, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (!done && n < 10) begin
            step();
            n++;
        end
        n_vec++;
        if (!done) begin
            n_miss++;
            $display("FAIL hold_done_timeout: no sDone within %0d cycles, required 1", n);
        end else if (n != 1) begin
            n_miss++;
            $display("FAIL hold_done_latency: sDone %0d cycles after last strobe, required 1", n);
        end
        chk_all(107, ONES, 4, 1'b0, 1'b1, 1'b0);
        step(); chk_all(108, ONES, 4, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
